// File: rtl/serial_tx_slot_scheduler.sv
// Transmit slot scheduler: 8-valid-in-10 framing with sync burst, alignment commas and user data.
// Optional SERIAL_TX_SLOT_SCHEDULER_STATS_EN adds saturating data/idle word counters.
module serial_tx_slot_scheduler #(
    parameter int          SYNC_WORDS   = 16,
    parameter int          COMMA_PERIOD = 256,
    parameter logic [7:0]  IDLE_CHAR    = 8'hBC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  s_data,
    input  logic        s_k,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  enc_data,
    output logic        enc_k,
    output logic        enc_valid,
    output logic        frame_start,
    output logic        link_up
`ifdef SERIAL_TX_SLOT_SCHEDULER_STATS_EN
    ,
    output logic [31:0] stat_data_cnt,
    output logic [31:0] stat_idle_cnt
`endif
);

    localparam logic [1:0] OFF  = 2'd0;
    localparam logic [1:0] SYNC = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    localparam logic [7:0]  SYNC_TGT   = 8'(SYNC_WORDS);
    localparam logic [15:0] COMMA_LAST = 16'(COMMA_PERIOD - 1);

    logic [1:0]  state, state_nxt;
    logic [3:0]  slot_cnt;
    logic [7:0]  sync_cnt;
    logic [15:0] comma_cnt;
    logic        valid_slot, frame_end, force_comma, take;

    assign valid_slot  = (state != OFF) && (slot_cnt < 4'd8);
    assign frame_end   = (state != OFF) && (slot_cnt == 4'd9);
    assign force_comma = (state == RUN) && valid_slot && (comma_cnt == COMMA_LAST);
    assign s_ready     = (state == RUN) && valid_slot && !force_comma;
    assign take        = s_ready && s_valid;

    // enable is only honoured at frame boundaries so no partial frame reaches the packer
    always_comb begin
        state_nxt = state;
        case (state)
            OFF:  if (enable) state_nxt = SYNC;
            SYNC: if (frame_end) begin
                      if (!enable)                    state_nxt = OFF;
                      else if (sync_cnt >= SYNC_TGT)  state_nxt = RUN;
                  end
            RUN:  if (frame_end && !enable) state_nxt = OFF;
            default: state_nxt = OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= OFF;
            slot_cnt    <= 4'd0;
            sync_cnt    <= 8'd0;
            comma_cnt   <= 16'd0;
            enc_valid   <= 1'b0;
            enc_data    <= 8'h00;
            enc_k       <= 1'b0;
            frame_start <= 1'b0;
            link_up     <= 1'b0;
        end else begin
            state       <= state_nxt;
            link_up     <= (state_nxt == RUN);
            enc_valid   <= valid_slot;
            frame_start <= valid_slot && (slot_cnt == 4'd0);

            if (state == OFF || slot_cnt == 4'd9) slot_cnt <= 4'd0;
            else                                  slot_cnt <= slot_cnt + 4'd1;

            if (state == OFF)
                sync_cnt <= 8'd0;
            else if (state == SYNC && valid_slot && sync_cnt < SYNC_TGT)
                sync_cnt <= sync_cnt + 8'd1;

            // alignment comma phase restarts on every entry into RUN
            if (state != RUN)
                comma_cnt <= 16'd0;
            else if (valid_slot)
                comma_cnt <= force_comma ? 16'd0 : comma_cnt + 16'd1;

            if (valid_slot) begin
                if (take) begin
                    enc_data <= s_data;
                    enc_k    <= s_k;
                end else begin
                    enc_data <= IDLE_CHAR;
                    enc_k    <= 1'b1;
                end
            end
        end
    end

`ifdef SERIAL_TX_SLOT_SCHEDULER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_data_cnt <= 32'd0;
            stat_idle_cnt <= 32'd0;
        end else begin
            if (take && stat_data_cnt != 32'hFFFF_FFFF)
                stat_data_cnt <= stat_data_cnt + 32'd1;
            if (s_ready && !s_valid && stat_idle_cnt != 32'hFFFF_FFFF)
                stat_idle_cnt <= stat_idle_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_tx_slot_scheduler.sv
// Directed bench for serial_tx_slot_scheduler: sync burst, data flow, idle fill,
// enable drop/re-enable, mid-frame reset, and a short-period instance for alignment commas.
module tb_serial_tx_slot_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, s_k, s_valid, s_ready;
    logic [7:0]  s_data, enc_data;
    logic        enc_k, enc_valid, frame_start, link_up;

    logic        enable2, s_k2, s_valid2, s_ready2;
    logic [7:0]  s_data2, enc_data2;
    logic        enc_k2, enc_valid2, frame_start2, link_up2;

`ifdef SERIAL_TX_SLOT_SCHEDULER_STATS_EN
    logic [31:0] stat_data_cnt, stat_idle_cnt, stat_data_cnt2, stat_idle_cnt2;
`endif

    int total  = 0;
    int passed = 0;
    int exp_data = 0;
    int exp_idle = 0;
    logic [7:0] nb, last;

    serial_tx_slot_scheduler #(.SYNC_WORDS(16), .COMMA_PERIOD(256), .IDLE_CHAR(8'hBC)) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_data(s_data), .s_k(s_k), .s_valid(s_valid), .s_ready(s_ready),
        .enc_data(enc_data), .enc_k(enc_k), .enc_valid(enc_valid),
        .frame_start(frame_start), .link_up(link_up)
`ifdef SERIAL_TX_SLOT_SCHEDULER_STATS_EN
        , .stat_data_cnt(stat_data_cnt), .stat_idle_cnt(stat_idle_cnt)
`endif
    );

    serial_tx_slot_scheduler #(.SYNC_WORDS(8), .COMMA_PERIOD(8), .IDLE_CHAR(8'hBC)) u_dut8 (
        .clk(clk), .rst(rst), .enable(enable2),
        .s_data(s_data2), .s_k(s_k2), .s_valid(s_valid2), .s_ready(s_ready2),
        .enc_data(enc_data2), .enc_k(enc_k2), .enc_valid(enc_valid2),
        .frame_start(frame_start2), .link_up(link_up2)
`ifdef SERIAL_TX_SLOT_SCHEDULER_STATS_EN
        , .stat_data_cnt(stat_data_cnt2), .stat_idle_cnt(stat_idle_cnt2)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(enc_valid), 32'd0);
        chk({tag, "_data"},  32'(enc_data), 32'd0);
        chk({tag, "_k"},     32'(enc_k), 32'd0);
        chk({tag, "_fs"},    32'(frame_start), 32'd0);
        chk({tag, "_link"},  32'(link_up), 32'd0);
        chk({tag, "_ready"}, 32'(s_ready), 32'd0);
    endtask

    // entry: state just became SYNC at slot 0; exit: RUN at slot 0
    task automatic check_sync;
        for (int i = 0; i < 20; i++) begin
            int s;
            s = i % 10;
            chk("sync_ready", 32'(s_ready), 32'd0);
            tick();
            chk("sync_valid", 32'(enc_valid), 32'(s < 8));
            if (s < 8) chk("sync_word", 32'({enc_k, enc_data}), 32'h1BC);
            chk("sync_fs", 32'(frame_start), 32'(s == 0));
            chk("sync_link", 32'(link_up), 32'(i == 19));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_k = 1'b0;
        enable2 = 1'b0; s_valid2 = 1'b0; s_data2 = 8'h00; s_k2 = 1'b0;
        tick(); tick();
        chk_reset_outputs("reset");

        rst = 1'b0;
        tick(); tick();
        chk("off_idle_valid", 32'(enc_valid), 32'd0);

        enable = 1'b1;
        tick();
        chk("sync_entry_valid", 32'(enc_valid), 32'd0);
        check_sync();

        // continuous data for three frames
        nb = 8'h00; last = 8'h00;
        s_valid = 1'b1;
        for (int j = 0; j < 30; j++) begin
            int s;
            s = j % 10;
            s_data = nb;
            chk("run_ready", 32'(s_ready), 32'(s < 8));
            tick();
            chk("run_valid", 32'(enc_valid), 32'(s < 8));
            if (s < 8) begin
                chk("run_data", 32'({enc_k, enc_data}), 32'({1'b0, nb}));
                last = nb;
                nb++;
                exp_data++;
            end else begin
                chk("run_gap_hold", 32'({enc_k, enc_data}), 32'({1'b0, last}));
            end
            chk("run_fs", 32'(frame_start), 32'(s == 0));
            chk("run_link", 32'(link_up), 32'd1);
        end

        // one full frame with no upstream data
        s_valid = 1'b0;
        for (int s = 0; s < 10; s++) begin
            chk("idle_ready", 32'(s_ready), 32'(s < 8));
            tick();
            chk("idle_valid", 32'(enc_valid), 32'(s < 8));
            if (s < 8) begin
                chk("idle_word", 32'({enc_k, enc_data}), 32'h1BC);
                exp_idle++;
            end
        end

        // data returns at slot 3
        for (int s = 0; s < 10; s++) begin
            s_valid = (s >= 3);
            s_data = nb;
            tick();
            if (s < 8) begin
                if (s >= 3) begin
                    chk("resume_data", 32'({enc_k, enc_data}), 32'({1'b0, nb}));
                    nb++;
                    exp_data++;
                end else begin
                    chk("resume_idle", 32'({enc_k, enc_data}), 32'h1BC);
                    exp_idle++;
                end
            end
        end
        s_valid = 1'b0;
`ifdef SERIAL_TX_SLOT_SCHEDULER_STATS_EN
        chk("stat_data_mid", stat_data_cnt, 32'd29);
        chk("stat_idle_mid", stat_idle_cnt, 32'd11);
`endif

        // enable dropped at slot 3: frame completes, then OFF
        for (int s = 0; s < 10; s++) begin
            if (s == 3) enable = 1'b0;
            tick();
            chk("drop_valid", 32'(enc_valid), 32'(s < 8));
            if (s < 8) begin
                chk("drop_word", 32'({enc_k, enc_data}), 32'h1BC);
                exp_idle++;
            end
            chk("drop_link", 32'(link_up), 32'(s != 9));
        end
        for (int i = 0; i < 5; i++) begin
            chk("off_ready", 32'(s_ready), 32'd0);
            tick();
            chk("off_valid", 32'(enc_valid), 32'd0);
            chk("off_link", 32'(link_up), 32'd0);
            chk("off_hold", 32'({enc_k, enc_data}), 32'h1BC);
        end

        // re-enable gives a full sync burst again
        enable = 1'b1;
        tick();
        chk("resync_entry_valid", 32'(enc_valid), 32'd0);
        check_sync();

        s_valid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            s_data = nb;
            tick();
            chk("rerun_data", 32'({enc_k, enc_data}), 32'({1'b0, nb}));
            nb++;
            exp_data++;
        end
`ifdef SERIAL_TX_SLOT_SCHEDULER_STATS_EN
        chk("stat_data_pre_rst", stat_data_cnt, 32'(exp_data));
        chk("stat_idle_pre_rst", stat_idle_cnt, 32'(exp_idle));
`endif

        // reset at slot 5 of RUN
        rst = 1'b1;
        tick();
        chk_reset_outputs("midrst");
`ifdef SERIAL_TX_SLOT_SCHEDULER_STATS_EN
        chk("midrst_stat_data", stat_data_cnt, 32'd0);
        chk("midrst_stat_idle", stat_idle_cnt, 32'd0);
`endif
        rst = 1'b0; s_valid = 1'b0; enable = 1'b0;
        tick();
        chk("post_rst_valid", 32'(enc_valid), 32'd0);

        // short alignment period instance: 7 user bytes then a forced comma per frame
        enable2 = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        chk("p8_link", 32'(link_up2), 32'd1);
        s_valid2 = 1'b1;
        nb = 8'h40;
        for (int j = 0; j < 30; j++) begin
            int s;
            s = j % 10;
            s_data2 = nb;
            chk("p8_ready", 32'(s_ready2), 32'(s < 7));
            tick();
            chk("p8_valid", 32'(enc_valid2), 32'(s < 8));
            chk("p8_fs", 32'(frame_start2), 32'(s == 0));
            if (s < 7) begin
                chk("p8_data", 32'({enc_k2, enc_data2}), 32'({1'b0, nb}));
                nb++;
            end else if (s == 7) begin
                chk("p8_comma", 32'({enc_k2, enc_data2}), 32'h1BC);
            end
        end
`ifdef SERIAL_TX_SLOT_SCHEDULER_STATS_EN
        chk("p8_stat_data", stat_data_cnt2, 32'd21);
        chk("p8_stat_idle", stat_idle_cnt2, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
